// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU engine with HI/LO and MTHI/MTLO, WIDTH-cycle CALC.
// Signed MULT/DIV need `MDU_SIGNED_EN; without it they behave as MULTU/DIVU.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, acc_nxt, fix_p;
  logic [WIDTH-1:0] m, a_abs, b_abs, fix_q, fix_r;
  logic [WIDTH:0] shifted, diff, sum;
  logic is_div, dbz, take, accept, last;
  assign take   = state == IDLE && start && !flush;
  assign accept = take && funct[5:2] == 4'b0110;
  assign last   = state == CALC && cnt == '0;
  assign busy   = state == CALC;
  assign done   = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == IDLE ? (accept ? CALC : IDLE) :
                state == CALC ? (flush ? IDLE : (cnt == '0 ? DONE : CALC)) : IDLE;
  end
  // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
  always_comb begin
    shifted = acc[2*WIDTH-1:WIDTH-1];
    diff    = shifted - {1'b0, m};
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
    acc_nxt = is_div ? {diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0], acc[WIDTH-2:0], ~diff[WIDTH]}
                     : {sum, acc[WIDTH-1:1]};
  end
`ifdef MDU_SIGNED_EN
  logic sa, sb, neg_p, neg_r;
  assign sa    = ~funct[0] & op_a[WIDTH-1];
  assign sb    = ~funct[0] & op_b[WIDTH-1];
  assign a_abs = sa ? -op_a : op_a;
  assign b_abs = sb ? -op_b : op_b;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      neg_p <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_p <= sa ^ sb;
      neg_r <= sa;
    end
  always_comb begin
    fix_p = neg_p ? -acc_nxt : acc_nxt;
    fix_q = neg_p ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
    fix_r = neg_r ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
  end
`else
  assign a_abs = op_a;
  assign b_abs = op_b;
  assign fix_p = acc_nxt;
  assign fix_q = acc_nxt[WIDTH-1:0];
  assign fix_r = acc_nxt[2*WIDTH-1:WIDTH];
`endif
  // a zero divisor leaves the remainder equal to the dividend, so only the quotient needs forcing
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      m      <= '0;
      is_div <= 1'b0;
      dbz    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      if (accept) begin
        cnt    <= CW'(WIDTH - 1);
        acc    <= {{WIDTH{1'b0}}, funct[1] ? a_abs : b_abs};
        m      <= funct[1] ? b_abs : a_abs;
        is_div <= funct[1];
        dbz    <= op_b == '0;
      end else if (busy) begin
        cnt <= cnt - 1'b1;
        acc <= acc_nxt;
      end
      if (last && !flush) begin
        hi <= is_div ? fix_r : fix_p[2*WIDTH-1:WIDTH];
        lo <= is_div ? (dbz ? '1 : fix_q) : fix_p[WIDTH-1:0];
      end
      if (take && funct == 6'h11) hi <= op_a;
      if (take && funct == 6'h13) lo <= op_a;
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: randomized and directed checks of mul_div_unit against a 64-bit arithmetic model.
module tb_mul_div_unit;
  localparam logic [5:0] MULT = 6'h18, MULTU = 6'h19, DIV = 6'h1A, DIVU = 6'h1B, MTHI = 6'h11, MTLO = 6'h13;
  logic clk = 0, rst_n = 0, start = 0, flush = 0;
  logic [5:0] funct = '0;
  logic [31:0] op_a = '0, op_b = '0, hi, lo;
  logic busy, done;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct(funct), .op_a(op_a), .op_b(op_b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic sg;
    longint sa, sb;
    sg = ~f[0];
`ifndef MDU_SIGNED_EN
    sg = 1'b0;
`endif
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!f[1]) return sg ? 64'(sa * sb) : {32'b0, a} * {32'b0, b};
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (sg) return {32'(sa % sb), 32'(sa / sb)};
    return {a % b, a / b};
  endfunction
  task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input int inj,
                       output logic [63:0] res, output int cyc, output int nbusy, output logic held);
    logic [63:0] prev;
    @(negedge clk);
    prev = {hi, lo};
    start = 1; funct = f; op_a = a; op_b = b;
    @(posedge clk);
    #1 start = 0;
    cyc = 0; nbusy = 0; held = 1; res = '0;
    for (int i = 1; i <= 96; i++) begin
      @(negedge clk);
      start = 0;
      if (done) begin
        cyc = i;
        res = {hi, lo};
        break;
      end
      if (busy) nbusy++;
      if ({hi, lo} != prev) held = 0;
      if (i == inj) begin
        start = 1; funct = MTHI; op_a = 32'h55;
      end
    end
  endtask
  task automatic run(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input int inj);
    logic [63:0] res;
    int cyc, nbusy;
    logic held;
    do_op(f, a, b, inj, res, cyc, nbusy, held);
    check({tag, " result"}, res, model(f, a, b));
    check({tag, " done_cycle"}, 64'(cyc), 64'd33);
    check({tag, " busy_cycles"}, 64'(nbusy), 64'd32);
    check({tag, " hilo_held"}, 64'(held), 64'd1);
  endtask
  task automatic mt(input string tag, input logic [5:0] f, input logic [31:0] v);
    @(negedge clk);
    start = 1; funct = f; op_a = v;
    @(posedge clk);
    #1 start = 0;
    @(negedge clk);
    check(tag, f == MTLO ? lo : hi, v);
    check({tag, " busy"}, 64'(busy), 64'd0);
  endtask
  initial begin
    logic [63:0] exp, saved;
    logic saw;
    logic [5:0] f;
    logic [31:0] a, b;
    @(negedge clk);
    check("rst hilo", {hi, lo}, 64'd0);
    check("rst busy_done", {busy, done}, 64'd0);
    rst_n = 1;
    run("multu 7x6", MULTU, 32'd7, 32'd6, 0);
    check("multu 7x6 directed", {hi, lo}, 64'h0000_0000_0000_002A);
    @(negedge clk);
    start = 1; funct = MULTU; op_a = 32'd5; op_b = 32'd9;
    @(posedge clk);
    #1 start = 0;
    repeat (10) @(negedge clk);
    check("pre-reset busy", 64'(busy), 64'd1);
    rst_n = 0;
    #1;
    check("async rst hilo", {hi, lo}, 64'd0);
    check("async rst busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1;
    run("mult -3x5", MULT, 32'hFFFF_FFFD, 32'd5, 0);
`ifdef MDU_SIGNED_EN
    check("mult -3x5 directed", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
`else
    check("mult -3x5 directed", {hi, lo}, 64'h0000_0004_FFFF_FFF1);
`endif
    run("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 0);
    run("divu 100/7", DIVU, 32'd100, 32'd7, 0);
    check("divu 100/7 directed", {hi, lo}, {32'd2, 32'd14});
    run("divu by zero", DIVU, 32'h1234_5678, 32'd0, 0);
    check("divu by zero directed", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
    run("div by zero neg", DIV, 32'hFFFF_FFF9, 32'd0, 0);
    run("div minint/-1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    mt("mtlo", MTLO, 32'hAAAA_0000);
    @(negedge clk);
    start = 1; funct = MULTU; op_a = 32'd3; op_b = 32'd3;
    @(posedge clk);
    #1 start = 0;
    repeat (5) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    check("flush busy", 64'(busy), 64'd0);
    saw = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw = 1;
    end
    check("flush no done", 64'(saw), 64'd0);
    check("flush lo kept", 64'(lo), 64'hAAAA_0000);
    @(negedge clk);
    start = 1; flush = 1; funct = MULTU; op_a = 32'd4; op_b = 32'd4;
    @(posedge clk);
    #1 start = 0; flush = 0;
    @(negedge clk);
    check("start+flush busy", 64'(busy), 64'd0);
    saved = {hi, lo};
    start = 1; flush = 1; funct = MTHI; op_a = 32'h77;
    @(posedge clk);
    #1 start = 0; flush = 0;
    @(negedge clk);
    check("mthi+flush ignored", {hi, lo}, saved);
    run("mthi in calc", MULTU, 32'h1234_5678, 32'h100, 3);
    run("b2b first", DIVU, 32'd1000, 32'd3, 0);
    run("b2b second", DIVU, 32'hDEAD_BEEF, 32'd17, 0);
    start = 1; funct = MULTU; op_a = 32'd2; op_b = 32'd2;
    @(posedge clk);
    #1 start = 0;
    @(negedge clk);
    check("start in done ignored", 64'(busy), 64'd0);
    run("flush in done op", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    exp = model(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    flush = 1;
    @(posedge clk);
    #1 flush = 0;
    @(negedge clk);
    check("flush in done kept", {hi, lo}, exp);
    for (int n = 0; n < 30; n++) begin
      f = {4'b0110, 2'($urandom_range(0, 3))};
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15)) | (b & 32'h8000_0000);
        default: ;
      endcase
      run($sformatf("rand%0d f%h", n, f), f, a, b, 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit beside the ALU in the EX stage. It executes the SPECIAL-opcode functs the single-cycle ALU cannot: MULT, MULTU, DIV, DIVU, MTHI and MTLO. Results go into an internal HI/LO register pair. `busy` stalls the pipeline while an operation is in flight, and `flush` aborts it on exceptions.

## Interface
- `WIDTH`, 32, operand width and HI/LO width; must be even and ≥ 4.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request: the EX stage holds a SPECIAL instruction with a funct below.
- `funct`  in  6  (`FUNCT_BUS`) SPECIAL funct field.
- `op_a`  in  WIDTH  rs value (multiplicand / dividend / MTHI/MTLO source).
- `op_b`  in  WIDTH  rt value (multiplier / divisor).
- `flush`  in  1  abort the in-flight operation; HI/LO are left unchanged.
- `busy`  out  1  high in CALC; the pipeline stalls while high.
- `done`  out  1  one-cycle pulse in DONE.
- `hi`, `lo`  out  WIDTH  architectural HI/LO.

## Operation
- Decode: 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU, 0x11 MTHI, 0x13 MTLO. Any other funct with `start` is ignored.
- States:
  - IDLE: accepts `start`.
  - CALC: iterates, with a counter running WIDTH-1 down to 0.
  - DONE: one cycle, then returns to IDLE.
- MTHI/MTLO in IDLE: `hi` (or `lo`) ← `op_a` at the next edge. No state change, `busy` stays low.
- MULT/MULTU/DIV/DIVU in IDLE: latch operands and op kind, then enter CALC.
- Signed ops:
  - Operands are converted to magnitudes and the unsigned core runs on them.
  - Product sign = sign(a) XOR sign(b).
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Negation is applied when writing HI/LO.
- Multiply: radix-2 shift-add, one bit per cycle, 2·WIDTH-bit accumulator. Result {hi,lo} = full 2·WIDTH-bit product.
- Divide: restoring, one quotient bit per cycle. `lo` = quotient, `hi` = remainder, truncating toward zero.
- Divide by zero: still takes WIDTH cycles. Result `lo` = all ones, `hi` = `op_a` (raw), no sign fix.
- Overflow case (signed DIV of min-int by -1): `lo` = min-int, `hi` = 0, which falls out of the magnitude arithmetic modulo 2^WIDTH.
- Boundary rules:
  - `start` in CALC or DONE: ignored, including MTHI/MTLO.
  - `flush` in CALC: return to IDLE next edge; `done` is not pulsed and HI/LO are unchanged.
  - `flush` in IDLE together with `start`: flush wins, nothing is accepted.
  - `flush` in DONE: no effect, because the result is already committed.
- Reset, asynchronous and at any time including mid-operation:
  - state IDLE, counter 0, operand latches 0.
  - `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0.

## Timing
- Edge 0 accepts `start`.
- `busy` is high for exactly WIDTH cycles (CALC), from edge 0 to edge WIDTH. `busy` is registered and does not depend combinationally on `start`; the hazard unit asserts the stall in the issue cycle by decoding `start`.
- HI/LO are written at edge WIDTH. `done` is high for the cycle between edges WIDTH and WIDTH+1.
- IDLE resumes at edge WIDTH+1, so back-to-back operations have a WIDTH+1 cycle period.
- MTHI/MTLO have 1-cycle latency.
- `hi`/`lo` hold their old values throughout CALC.

## Configuration
- `MDU_SIGNED_EN` defined:
  - MULT/DIV perform signed arithmetic as above.
  - Sign-correction logic is present.
- `MDU_SIGNED_EN` undefined:
  - MULT behaves exactly as MULTU, and DIV exactly as DIVU.
  - No negation logic is synthesised.
  - Timing is unchanged.

## Test plan
- Reset:
  - MULTU 7×6 → after 32 CALC cycles `done`=1, `hi`=0, `lo`=0x0000002A.
  - Assert `rst_n`=0 at CALC cycle 10 → `busy`=0, `hi`=`lo`=0 immediately.
- Signed multiply (MDU_SIGNED_EN): MULT 0xFFFFFFFD×5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. Without the macro → `hi`=0x00000004, `lo`=0xFFFFFFF1.
- Signed divide: DIV 0xFFFFFFF9 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 100/7 → `lo`=14, `hi`=2.
- Divide by zero: DIVU 0x12345678/0 → `lo`=0xFFFFFFFF, `hi`=0x12345678, `done` at cycle 33.
- Flush: MTLO 0xAAAA0000, then MULTU 3×3, then `flush` at CALC cycle 5 → IDLE next cycle, no `done`, `lo`=0xAAAA0000. Simultaneous `start`+`flush` in IDLE → `busy` stays 0.
- Busy ignore:
  - MTHI 0x55 issued during CALC → ignored, `hi` = product after DONE.
  - Back-to-back DIVU issued the cycle after `done` → accepted, second `done` 33 cycles later.
